// File: rtl/shared_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
//   arb_state_e : arbiter FSM states
//   rr_ptr_w()  : round-robin pointer width for a requester count (at least 1)
//   RR_PTR_W    : pointer width for the default requester count
//   STATS_W     : width of the optional statistics counters
package shared_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    STALL = 2'd2
  } arb_state_e;

  localparam int unsigned NUM_REQ_DEFAULT = 4;
  localparam int unsigned STATS_W         = 16;

  // $clog2 of the requester count, never narrower than one bit
  function automatic int unsigned rr_ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned RR_PTR_W = rr_ptr_w(NUM_REQ_DEFAULT);

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between the requesters, the arbiter and the FIFO write port.
//   req/req_data        : requester write requests and their data words
//   gnt/done/err        : per-requester grant, write-acked and overflow pulses
//   wr_en/data_in       : FIFO write port
//   full/almostfull     : FIFO status flags
//   wr_ack/overflow     : FIFO write response
// Modports: slave = arbiter side, master = clients + FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned FIFO_WIDTH = 16
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            done;
  logic [NUM_REQ-1:0]            err;
  logic                          wr_en;
  logic [FIFO_WIDTH-1:0]         data_in;
  logic                          full;
  logic                          almostfull;
  logic                          wr_ack;
  logic                          overflow;

  modport slave (
    input  req, req_data, full, almostfull, wr_ack, overflow,
    output gnt, done, err, wr_en, data_in
  );

  modport master (
    output req, req_data, full, almostfull, wr_ack, overflow,
    input  gnt, done, err, wr_en, data_in
  );
endinterface

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: searches req upward from rr_ptr,
// wrapping at NUM_REQ, and returns the first set index.
//   req_i      : request vector
//   rr_ptr_i   : highest-priority index this round
//   valid_c_o  : at least one request is set
//   winner_c_o : index of the winning requester
module fifo_rr_pick
  import shared_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = RR_PTR_W
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   rr_ptr_i,
  output logic               valid_c_o,
  output logic [PTR_W-1:0]   winner_c_o
);

  always_comb begin
    int unsigned idx;
    valid_c_o  = 1'b0;
    winner_c_o = '0;
    idx        = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(rr_ptr_i) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!valid_c_o && req_i[PTR_W'(idx)]) begin
        valid_c_o  = 1'b1;
        winner_c_o = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// Issues at most one registered write per cycle, throttles on full/almostfull
// so it never overflows the FIFO itself, and steers wr_ack/overflow back to
// the requester that owned each write as done/err pulses.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fifo_wr_arbiter_if.slave (requesters + FIFO write port)
//   wr_cnt     : per-requester saturating done counters (FIFO_ARB_STATS_EN)
//   ovf_cnt    : saturating err counter (FIFO_ARB_STATS_EN)
// Optional feature macro: FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
  import shared_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fifo_wr_arbiter_if.slave        bus
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STATS_W-1:0] wr_cnt,
  output logic [STATS_W-1:0]         ovf_cnt
`endif
);

  localparam int unsigned PTR_W = rr_ptr_w(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || FIFO_WIDTH < 1 || FIFO_DEPTH < 1) begin : g_param_chk
    $error("fifo_wr_arbiter: unsupported parameter set");
  end

  arb_state_e            state_q, state_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]      owner_q, owner_d;
  logic [PTR_W-1:0]      owner_dly_q;   // owner of the write the FIFO is answering now
  logic                  vld_dly_q;     // a write of ours was issued last cycle
  logic                  wr_en_q, wr_en_d;
  logic [FIFO_WIDTH-1:0] data_q, data_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic [NUM_REQ-1:0]    err_q, err_d;
  logic                  pick_valid;
  logic [PTR_W-1:0]      pick_idx;
  logic                  can_issue;

  fifo_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req_i      (bus.req),
    .rr_ptr_i   (rr_ptr_q),
    .valid_c_o  (pick_valid),
    .winner_c_o (pick_idx)
  );

  // Conservative throttle: with a write in flight, almostfull already blocks.
  assign can_issue = !bus.full && !(bus.almostfull && (state_q == WRITE));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = IDLE;
    if (pick_valid) state_d = can_issue ? WRITE : STALL;
  end

  // Output / datapath next values
  always_comb begin
    wr_en_d  = 1'b0;
    gnt_d    = '0;
    data_d   = data_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    done_d   = '0;
    err_d    = '0;
    if (state_d == WRITE) begin
      wr_en_d        = 1'b1;
      gnt_d[pick_idx] = 1'b1;
      data_d         = bus.req_data[pick_idx*FIFO_WIDTH +: FIFO_WIDTH];
      owner_d        = pick_idx;
      rr_ptr_d       = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : PTR_W'(pick_idx + 1'b1);
    end
    // Responses without one of our writes in flight are ignored.
    done_d[owner_dly_q] = bus.wr_ack   & vld_dly_q;
    err_d[owner_dly_q]  = bus.overflow & vld_dly_q;
  end

  // Registered outputs and tracking state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q     <= 1'b0;
      data_q      <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      owner_dly_q <= '0;
      vld_dly_q   <= 1'b0;
    end else begin
      wr_en_q     <= wr_en_d;
      data_q      <= data_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      owner_dly_q <= owner_q;
      vld_dly_q   <= wr_en_q;
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.data_in = data_q;
  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

`ifdef FIFO_ARB_STATS_EN
  // Per-requester saturating count of acknowledged writes
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_wr_cnt
    logic [STATS_W-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       cnt_q <= '0;
      else if (done_q[k] && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
    assign wr_cnt[k*STATS_W +: STATS_W] = cnt_q;
  end

  // Saturating count of overflow-reported writes (err is one-hot per cycle)
  logic [STATS_W-1:0] ovf_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        ovf_cnt_q <= '0;
    else if ((|err_q) && ovf_cnt_q != '1) ovf_cnt_q <= ovf_cnt_q + 1'b1;
  end
  assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter with a small FIFO model
// (depth 8, almostfull at 7 entries) and an expected-result scoreboard.
module tb_fifo_wr_arbiter;
  import shared_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned W  = 16;
  localparam int          D  = 8;

  typedef struct packed {
    logic [NR-1:0] gnt;
    logic [W-1:0]  data;
  } wr_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .FIFO_WIDTH(W)) bus ();

`ifdef FIFO_ARB_STATS_EN
  logic [NR*16-1:0] wr_cnt;
  logic [15:0]      ovf_cnt;
`endif

  fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .FIFO_WIDTH (W),
    .FIFO_DEPTH (D)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus)
`ifdef FIFO_ARB_STATS_EN
    ,
    .wr_cnt  (wr_cnt),
    .ovf_cnt (ovf_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int wr_seen = 0;
  int ovf_seen = 0;

  wr_exp_t       exp_wr_q[$];
  logic [NR-1:0] exp_done_q[$];
  logic [NR-1:0] exp_err_q[$];

  // FIFO model
  int   cnt = 0;
  logic fifo_rd, fifo_flush, inj_ovf, inj_ack;
  assign bus.full       = (cnt == D);
  assign bus.almostfull = (cnt == D - 1);

  always @(posedge clk) begin
    if (fifo_flush) begin
      cnt          <= 0;
      bus.wr_ack   <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      bus.wr_ack   <= (bus.wr_en && !bus.full && !inj_ovf) || inj_ack;
      bus.overflow <= bus.wr_en && (bus.full || inj_ovf);
      cnt <= cnt + ((bus.wr_en && !bus.full && !inj_ovf) ? 1 : 0)
                 - ((fifo_rd && cnt > 0) ? 1 : 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic flush();
    fifo_flush = 1'b1;
    tick(1);
    fifo_flush = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  task automatic push_wr(input logic [NR-1:0] g, input logic [W-1:0] d, input bit with_done);
    wr_exp_t e;
    e.gnt  = g;
    e.data = d;
    exp_wr_q.push_back(e);
    if (with_done) exp_done_q.push_back(g);
  endtask

  task automatic set_data(input int k, input logic [W-1:0] v);
    bus.req_data[k*W +: W] = v;
  endtask

  // Scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    wr_exp_t       e;
    logic [NR-1:0] v;
    if (rst_n) begin
      if (bus.overflow) ovf_seen++;
      if (bus.wr_en) begin
        wr_seen++;
        chk("mon_wr_expected", 32'(exp_wr_q.size() != 0), 32'd1);
        if (exp_wr_q.size() != 0) begin
          e = exp_wr_q.pop_front();
          chk("mon_gnt", 32'(bus.gnt), 32'(e.gnt));
          chk("mon_data_in", 32'(bus.data_in), 32'(e.data));
        end
      end else begin
        chk("mon_idle_gnt", 32'(bus.gnt), 32'd0);
      end
      if (bus.done != '0) begin
        chk("mon_done_expected", 32'(exp_done_q.size() != 0), 32'd1);
        if (exp_done_q.size() != 0) begin
          v = exp_done_q.pop_front();
          chk("mon_done", 32'(bus.done), 32'(v));
        end
      end
      if (bus.err != '0) begin
        chk("mon_err_expected", 32'(exp_err_q.size() != 0), 32'd1);
        if (exp_err_q.size() != 0) begin
          v = exp_err_q.pop_front();
          chk("mon_err", 32'(bus.err), 32'(v));
        end
      end
    end
  end

  initial begin
    int base;
    bus.req      = '0;
    bus.req_data = '0;
    fifo_rd      = 1'b0;
    fifo_flush   = 1'b1;
    inj_ovf      = 1'b0;
    inj_ack      = 1'b0;
    rst_n        = 1'b0;

    // Reset state
    tick(2);
    chk("rst_wr_en",   32'(bus.wr_en),   32'd0);
    chk("rst_gnt",     32'(bus.gnt),     32'd0);
    chk("rst_done",    32'(bus.done),    32'd0);
    chk("rst_err",     32'(bus.err),     32'd0);
    chk("rst_data_in", 32'(bus.data_in), 32'd0);
    rst_n      = 1'b1;
    fifo_flush = 1'b0;
    tick(1);

    // Single requester: grant in T, done in T+2
    set_data(2, 16'hA5A5);
    bus.req = 4'b0100;
    push_wr(4'b0100, 16'hA5A5, 1'b1);
    tick(1);
    bus.req = '0;
    chk("single_gnt",   32'(bus.gnt),     32'h4);
    chk("single_wr_en", 32'(bus.wr_en),   32'd1);
    chk("single_data",  32'(bus.data_in), 32'hA5A5);
    tick(1);
    chk("single_done_t1", 32'(bus.done), 32'd0);
    tick(1);
    chk("single_done_t2", 32'(bus.done), 32'h4);
    tick(3);
    flush();

    // Fairness: all requesting, empty FIFO, rotation from requester 0
    pulse_reset();
    for (int k = 0; k < NR; k++) set_data(k, 16'(16'h1000 + k));
    for (int i = 0; i < 8; i++) push_wr(4'(1 << (i % 4)), 16'(16'h1000 + (i % 4)), 1'b1);
    bus.req = 4'hF;
    tick(8);
    bus.req = '0;
    tick(4);
    chk("fair_drained", 32'(exp_done_q.size()), 32'd0);
    flush();

    // Back-pressure: eight writes fill the FIFO, then a stall
    for (int i = 0; i < 8; i++) push_wr(4'(1 << (i % 4)), 16'(16'h1000 + (i % 4)), 1'b1);
    push_wr(4'b0001, 16'h1000, 1'b1);
    base    = wr_seen;
    bus.req = 4'hF;
    tick(12);
    chk("bp_writes",  32'(wr_seen - base), 32'd8);
    chk("bp_state",   32'(dut.state_q),    32'(STALL));
    chk("bp_gnt",     32'(bus.gnt),        32'd0);
    chk("bp_wr_en",   32'(bus.wr_en),      32'd0);
    chk("bp_no_ovf",  32'(ovf_seen),       32'd0);
    fifo_rd = 1'b1;
    tick(1);
    fifo_rd = 1'b0;
    tick(1);
    chk("bp_resume_gnt", 32'(bus.gnt), 32'h1);
    tick(3);
    chk("bp_restall", 32'(dut.state_q),    32'(STALL));
    chk("bp_writes2", 32'(wr_seen - base), 32'd9);
    bus.req = '0;
    tick(4);
    chk("bp_no_ovf2", 32'(ovf_seen), 32'd0);
    chk("bp_drained", 32'(exp_done_q.size()), 32'd0);
    flush();

    // FIFO-reported overflow steered to the owner as err
    inj_ovf = 1'b1;
    set_data(1, 16'hBEEF);
    bus.req = 4'b0010;
    push_wr(4'b0010, 16'hBEEF, 1'b0);
    exp_err_q.push_back(4'b0010);
    tick(1);
    bus.req = '0;
    chk("xovf_gnt", 32'(bus.gnt), 32'h2);
    tick(1);
    chk("xovf_err_t1", 32'(bus.err), 32'd0);
    tick(1);
    chk("xovf_err_t2",  32'(bus.err),  32'h2);
    chk("xovf_done_t2", 32'(bus.done), 32'd0);
    inj_ovf = 1'b0;
    tick(2);

    // Stray wr_ack with nothing in flight
    inj_ack = 1'b1;
    tick(1);
    inj_ack = 1'b0;
    tick(1);
    chk("stray_done_a", 32'(bus.done), 32'd0);
    tick(1);
    chk("stray_done_b", 32'(bus.done), 32'd0);
    tick(2);

    // Reset while writes are in flight
    set_data(3, 16'h5A5A);
    bus.req = 4'b1000;
    push_wr(4'b1000, 16'h5A5A, 1'b0);
    tick(1);
    chk("mid_gnt", 32'(bus.gnt), 32'h8);
    tick(1);
    chk("mid_wr_en_pre", 32'(bus.wr_en), 32'd1);
    rst_n   = 1'b0;
    bus.req = '0;
    #1;
    chk("mid_rst_wr_en",   32'(bus.wr_en),   32'd0);
    chk("mid_rst_gnt",     32'(bus.gnt),     32'd0);
    chk("mid_rst_data_in", 32'(bus.data_in), 32'd0);
    chk("mid_rst_done",    32'(bus.done),    32'd0);
    chk("mid_rst_err",     32'(bus.err),     32'd0);
    rst_n = 1'b1;
    tick(1);
    chk("mid_post_done_a", 32'(bus.done), 32'd0);
    tick(1);
    chk("mid_post_done_b", 32'(bus.done), 32'd0);
    chk("mid_post_err",    32'(bus.err),  32'd0);
    tick(2);
    flush();

`ifdef FIFO_ARB_STATS_EN
    // Statistics: five writes from requester 2
    pulse_reset();
    set_data(2, 16'h0C00);
    for (int i = 0; i < 5; i++) push_wr(4'b0100, 16'h0C00, 1'b1);
    bus.req = 4'b0100;
    tick(5);
    bus.req = '0;
    tick(4);
    for (int k = 0; k < NR; k++)
      chk($sformatf("stats_wr_cnt%0d", k), 32'(wr_cnt[k*16 +: 16]), (k == 2) ? 32'd5 : 32'd0);
    chk("stats_ovf_cnt", 32'(ovf_cnt), 32'd0);
    flush();
`endif

    chk("end_wr_q",   32'(exp_wr_q.size()),   32'd0);
    chk("end_done_q", 32'(exp_done_q.size()), 32'd0);
    chk("end_err_q",  32'(exp_err_q.size()),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
